ro_gray_sched: RTL

Parametrised Gray-slot readout scheduler for the channel array. An internal N_CH-bit Gray counter divides time into slots. In each enabled cycle exactly one Gray bit toggles, and the channel with that bit's index owns the shared readout word. Channel k is therefore read at roughly f_clk/2^(k+1), giving the faster channels the faster readout. Events arriving between a channel's slots are held in sticky per-channel flags, so no pulse is lost before that channel is read.

---
 rtl/ro_gray_sched.sv | 121 ++++++++++++
 1 files changed

// File: rtl/ro_gray_sched.sv
// rtl/ro_gray_sched.sv - Gray-slot readout scheduler with sticky per-channel event flags
// Optional per-channel overflow tracking is enabled by defining RO_OVF_EN.
module ro_gray_sched #(
  parameter int  N_CH = 8,
  localparam int CH_W = $clog2(N_CH)
) (
  input  logic             clk_master,
  input  logic             rstb,
  input  logic             en,
  input  logic [N_CH-1:0]  in_eve,
  input  logic [N_CH-1:0]  in_pol_eve,
  output logic [N_CH-1:0]  gray_count,
  output logic             out_valid,
  output logic [CH_W-1:0]  out_ch,
  output logic             out_eve,
  output logic             out_pol_eve,
  output logic             out_ovf,
  output logic             frame
);

  localparam logic [N_CH-1:0] B_ONE = {{(N_CH-1){1'b0}}, 1'b1};

  logic [N_CH-1:0] b_q, b_d;
  logic [N_CH-1:0] pend_eve_q, pend_eve_d;
  logic [N_CH-1:0] pend_pol_q, pend_pol_d;
  logic            out_valid_q, out_valid_d;
  logic [CH_W-1:0] out_ch_q, out_ch_d;
  logic            out_eve_q, out_eve_d;
  logic            out_pol_q, out_pol_d;
  logic            frame_q, frame_d;

  logic [CH_W-1:0] sel;
  logic            sel_found;
  logic [N_CH-1:0] read_mask;

  // The toggling Gray bit is the trailing-ones count of b; the top channel owns the wrap slot.
  always_comb begin
    sel       = CH_W'(N_CH - 1);
    sel_found = 1'b0;
    for (int i = 0; i < N_CH - 1; i++) begin
      if (!sel_found && !b_q[i]) begin
        sel       = CH_W'(i);
        sel_found = 1'b1;
      end
    end
  end

  always_comb begin
    read_mask      = '0;
    read_mask[sel] = en;
  end

  // Capture ORs in after the read clear, so a same-cycle event survives its own read.
  always_comb begin
    b_d         = en ? b_q + B_ONE : b_q;
    pend_eve_d  = (pend_eve_q & ~read_mask) | in_eve;
    pend_pol_d  = (pend_pol_q & ~read_mask) | in_pol_eve;
    out_valid_d = en;
    out_ch_d    = en ? sel : out_ch_q;
    out_eve_d   = en ? pend_eve_q[sel] : out_eve_q;
    out_pol_d   = en ? pend_pol_q[sel] : out_pol_q;
    frame_d     = en && (b_q == '1);
  end

  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      b_q         <= '0;
      pend_eve_q  <= '0;
      pend_pol_q  <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_eve_q   <= 1'b0;
      out_pol_q   <= 1'b0;
      frame_q     <= 1'b0;
    end else begin
      b_q         <= b_d;
      pend_eve_q  <= pend_eve_d;
      pend_pol_q  <= pend_pol_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_eve_q   <= out_eve_d;
      out_pol_q   <= out_pol_d;
      frame_q     <= frame_d;
    end
  end

`ifdef RO_OVF_EN
  logic [N_CH-1:0] ovf_q, ovf_d;
  logic [N_CH-1:0] ovf_set;
  logic            out_ovf_q, out_ovf_d;

  // A second event on an unread channel means the first one was merged away.
  always_comb begin
    ovf_set   = in_eve & pend_eve_q & ~read_mask;
    ovf_d     = (ovf_q & ~read_mask) | ovf_set;
    out_ovf_d = en ? ovf_q[sel] : out_ovf_q;
  end

  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      ovf_q     <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      ovf_q     <= ovf_d;
      out_ovf_q <= out_ovf_d;
    end
  end

  assign out_ovf = out_ovf_q;
`else
  assign out_ovf = 1'b0;
`endif

  assign gray_count  = b_q ^ (b_q >> 1);
  assign out_valid   = out_valid_q;
  assign out_ch      = out_ch_q;
  assign out_eve     = out_eve_q;
  assign out_pol_eve = out_pol_q;
  assign frame       = frame_q;

endmodule
